// File: rtl/uart_pkg.sv
// Shared types and constants for the UART response transmitter.
// Frame length depends on UART_PARITY_EN (adds an even-parity bit when defined).
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

`ifdef UART_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  localparam int BYTES_PER_PAIR = 2;

  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/uart_resp_tx_if.sv
// Request handshake between the report logic (master) and the transmitter (slave).
interface uart_resp_tx_if;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_code;
  logic [7:0] req_data;

  modport master (output req_valid, output req_code, output req_data, input req_ready);
  modport slave  (input req_valid, input req_code, input req_data, output req_ready);
endinterface

// File: rtl/uart_resp_tx_baud_tick.sv
// Bit-period timer: one-cycle tick every CLKS_PER_BIT clocks; srst holds the count at zero.
module baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic srst,
  output logic tick
);

  localparam int W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] cnt_r;

  // baud counter, wraps at the end of each bit period
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= '0;
    end else if (srst) begin
      cnt_r <= '0;
    end else if (cnt_r == LAST) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + W'(1);
    end
  end

  assign tick = (cnt_r == LAST) && !srst;

endmodule

// File: rtl/uart_resp_tx.sv
// Serializes a (code, data) byte pair as two back-to-back UART frames, LSB first.
// Define UART_PARITY_EN to insert an even-parity bit before each stop bit.
module uart_resp_tx
  import uart_pkg::*;
#(
  parameter int CLK_HZ       = 50000000,
  parameter int BAUD         = 9600,
  parameter int CLKS_PER_BIT = CLK_HZ / BAUD
) (
  input  logic           clk,
  input  logic           rst,
  uart_resp_tx_if.slave  bus,
  output logic           tx,
  output logic           busy,
  output logic           done
);

  state_t      state_r, state_s;
  logic [15:0] shift_r, shift_s;
  logic [2:0]  bit_idx_r, bit_idx_s;
  logic        byte_idx_r, byte_idx_s;
  logic        par_r, par_s;
  logic        tx_r, tx_s;
  logic        done_r, done_s;
  logic        busy_r, ready_r;
  logic        tick_s;
  logic        clr_s;

  assign clr_s = (state_r == IDLE);

  baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk  (clk),
    .rst  (rst),
    .srst (clr_s),
    .tick (tick_s)
  );

  // next-state, datapath and next line level
  always_comb begin
    state_s    = state_r;
    shift_s    = shift_r;
    bit_idx_s  = bit_idx_r;
    byte_idx_s = byte_idx_r;
    par_s      = par_r;
    done_s     = 1'b0;
    tx_s       = 1'b1;

    case (state_r)
      IDLE: begin
        if (bus.req_valid) begin
          state_s    = START;
          shift_s    = {bus.req_data, bus.req_code};
          bit_idx_s  = 3'd0;
          byte_idx_s = 1'b0;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (tick_s) begin
          state_s   = DATA;
          bit_idx_s = 3'd0;
          par_s     = even_parity(shift_r[7:0]);
        end else begin
          state_s = START;
        end
      end
      DATA: begin
        if (tick_s) begin
          // the second byte slides into [7:0] once the first is shifted out
          shift_s = {1'b1, shift_r[15:1]};
          if (bit_idx_r == 3'd7) begin
`ifdef UART_PARITY_EN
            state_s = PARITY;
`else
            state_s = STOP;
`endif
            bit_idx_s = 3'd0;
          end else begin
            bit_idx_s = bit_idx_r + 3'd1;
          end
        end else begin
          state_s = DATA;
        end
      end
      PARITY: begin
        if (tick_s) begin
          state_s = STOP;
        end else begin
          state_s = PARITY;
        end
      end
      STOP: begin
        if (tick_s) begin
          if (byte_idx_r == 1'(BYTES_PER_PAIR - 2)) begin
            state_s    = START;
            byte_idx_s = 1'b1;
          end else begin
            state_s = IDLE;
            done_s  = 1'b1;
          end
        end else begin
          state_s = STOP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    // line level follows the upcoming state so tx changes on the same edge
    case (state_s)
      START:   tx_s = 1'b0;
      DATA:    tx_s = shift_s[0];
      PARITY:  tx_s = par_s;
      STOP:    tx_s = 1'b1;
      default: tx_s = 1'b1;
    endcase
  end

  // state and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      shift_r    <= 16'h0000;
      bit_idx_r  <= 3'd0;
      byte_idx_r <= 1'b0;
      par_r      <= 1'b0;
      tx_r       <= 1'b1;
      done_r     <= 1'b0;
      busy_r     <= 1'b0;
      ready_r    <= 1'b1;
    end else begin
      state_r    <= state_s;
      shift_r    <= shift_s;
      bit_idx_r  <= bit_idx_s;
      byte_idx_r <= byte_idx_s;
      par_r      <= par_s;
      tx_r       <= tx_s;
      done_r     <= done_s;
      busy_r     <= (state_s != IDLE);
      ready_r    <= (state_s == IDLE);
    end
  end

  assign bus.req_ready = ready_r;
  assign tx            = tx_r;
  assign busy          = busy_r;
  assign done          = done_r;

endmodule

// File: tb/tb_uart_resp_tx.sv
// Scoreboard bench for uart_resp_tx: accepted pairs queue expected frames, a line
// receiver decodes tx at bit centres and compares against a frame model.
module tb_uart_resp_tx;
  import uart_pkg::*;

  localparam int CPB  = 16;
  localparam int FB   = FRAME_BITS;
  localparam int PAIR = 2 * FB * CPB;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tx, busy, done;

  uart_resp_tx_if bus ();

  uart_resp_tx #(.CLK_HZ(16), .BAUD(1)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave),
    .tx   (tx),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] val;
    int         start;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int busy_until = 0;
  int acc_cnt = 0;
  int last_acc = 0;

  logic        rx_act = 1'b0;
  int          rx_pos = 0;
  int          rx_start = 0;
  logic [10:0] rx_frame = 11'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // line image of one frame, index 0 = first bit on the wire
  function automatic logic [10:0] model_frame(input logic [7:0] b);
    logic [10:0] f;
    f = 11'd0;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1 + i] = b[i];
    if (FB == 11) begin
      f[9]  = ^b;
      f[10] = 1'b1;
    end else begin
      f[9] = 1'b1;
    end
    return f;
  endfunction

  // accept observer: records what the bench drove when the handshake fires
  initial begin
    forever begin
      @(posedge clk);
      if (rst && bus.req_valid && bus.req_ready) begin
        exp_t e;
        e.val = bus.req_code; e.start = cyc + 1;          q.push_back(e);
        e.val = bus.req_data; e.start = cyc + 1 + FB*CPB; q.push_back(e);
        busy_until = cyc + 1 + PAIR;
        last_acc   = cyc;
        acc_cnt++;
      end
      cyc++;
    end
  end

  // per-cycle status checks and serial receiver
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        q.delete();
        busy_until = 0;
        rx_act = 1'b0;
        check("rst_tx", tx, 1);
        check("rst_ready", bus.req_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
      end else begin
        check("busy", busy, (cyc < busy_until) ? 1 : 0);
        check("ready", bus.req_ready, (cyc < busy_until) ? 0 : 1);
        check("done", done, (busy_until != 0 && cyc == busy_until) ? 1 : 0);
        if (cyc >= busy_until) check("idle_tx", tx, 1);
        if (!rx_act) begin
          if (tx == 1'b0) begin
            rx_act = 1'b1; rx_pos = 0; rx_start = cyc; rx_frame = 11'd0;
          end
        end else begin
          rx_pos++;
        end
        if (rx_act && (rx_pos % CPB) == CPB/2) begin
          rx_frame[rx_pos / CPB] = tx;
          if (rx_pos / CPB == FB - 1) begin
            rx_act = 1'b0;
            check("frame_expected", (q.size() > 0) ? 1 : 0, 1);
            if (q.size() > 0) begin
              exp_t e;
              e = q.pop_front();
              check("frame_start", rx_start, e.start);
              check("frame_bits", rx_frame, model_frame(e.val));
            end
          end
        end
      end
    end
  end

  task automatic send(input logic [7:0] c, input logic [7:0] d, input bit keep);
    int n0;
    n0 = acc_cnt;
    bus.req_code  = c;
    bus.req_data  = d;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 3*PAIR && acc_cnt == n0; i++) @(negedge clk);
    check("accept", (acc_cnt != n0) ? 1 : 0, 1);
    if (!keep) bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 3*PAIR && cyc <= busy_until; i++) @(negedge clk);
    check("idle_reached", (cyc > busy_until) ? 1 : 0, 1);
  endtask

  initial begin
    int a1, n0;
    bus.req_valid = 1'b0;
    bus.req_code  = 8'h00;
    bus.req_data  = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (100) @(negedge clk);

    send(8'hA5, 8'h3C, 1'b0);
    wait_idle();

    // valid stays high with churning data; only the done cycle may re-accept
    n0 = acc_cnt;
    send(8'h11, 8'h22, 1'b1);
    repeat (PAIR + 40) begin
      @(negedge clk);
      bus.req_code = 8'($urandom);
      bus.req_data = 8'($urandom);
    end
    bus.req_valid = 1'b0;
    check("hs_accepts", acc_cnt - n0, 2);
    wait_idle();

    send(8'h01, 8'h02, 1'b1);
    a1 = last_acc;
    send(8'h03, 8'h04, 1'b0);
    check("b2b_gap", last_acc - a1, PAIR + 1);
    wait_idle();

    send(8'h55, 8'h07, 1'b0);
    wait_idle();
    send(8'hAA, 8'h03, 1'b0);
    wait_idle();
    for (int k = 0; k < 6; k++) begin
      send(8'($urandom), 8'($urandom), 1'b0);
      repeat ($urandom_range(0, 20)) @(negedge clk);
      wait_idle();
    end

    // reset 100 cycles into a pair
    send(8'h96, 8'h69, 1'b0);
    repeat (99) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_tx", tx, 1);
    check("async_ready", bus.req_ready, 1);
    check("async_busy", busy, 0);
    check("async_done", done, 0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    send(8'h5A, 8'hC3, 1'b0);
    wait_idle();

    repeat (20) @(negedge clk);
    check("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_resp_tx.md
Name: uart_resp_tx

Overview:
- Transmit end of the sensor-report path: takes a 2-byte response (command/status code + data byte) from the continuous-read / control logic via valid/ready handshake.
- Serializes both bytes back-to-back as UART 8N1 frames on `tx`, LSB first: code byte then data byte.
- Pulses `done` when the second frame's stop bit completes, so upstream logic can schedule the next periodic report.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- BAUD, 9600, line rate in bit/s.
- CLKS_PER_BIT, CLK_HZ/BAUD (5208), clocks per UART bit; must be >= 2.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-low.
- req_valid  input  1  upstream has a response pair ready.
- req_code  input  8  first byte (response code).
- req_data  input  8  second byte (sensor data).
- req_ready  output  1  block can accept a pair; high only in IDLE.
- tx  output  1  serial line, idle high.
- busy  output  1  high while a pair is in flight (any state but IDLE).
- done  output  1  one-cycle pulse at end of pair.

Behaviour:
- Reset (rst low, async): state=IDLE, tx=1, req_ready=1, busy=0, done=0, bit/baud counters=0, byte index=0. Takes effect immediately. A frame cut mid-transmission is abandoned with no `done`.
- Accept: req_valid & req_ready at a rising edge latches req_code and req_data into a 16-bit shift holding register. Inputs are ignored afterwards until the next IDLE.
- FSM states: IDLE, START, DATA, [PARITY], STOP.
  - IDLE -> START on accept.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA -> [PARITY|]STOP after 8 bits.
  - STOP -> START if byte index=0; index becomes 1.
  - STOP -> IDLE if byte index=1.
- Latency: tx drives 0 (start bit) on the cycle after the accept edge.
- Each bit holds for exactly CLKS_PER_BIT clocks. The baud counter runs 0..CLKS_PER_BIT-1 and resets at every state/bit change.
- Line levels: START drives 0. DATA drives the current byte bit[i], i=0..7. STOP drives 1.
- Pair timing: the second byte's start bit follows the first stop bit with zero idle gap. A full pair occupies 20*CLKS_PER_BIT cycles (22* with parity).
- done: registered, asserted for exactly 1 cycle, in the cycle the FSM re-enters IDLE. req_ready rises in that same cycle, so back-to-back pairs are possible: an accept in the done cycle starts the next START the following cycle.
- busy = (state != IDLE). req_ready = (state == IDLE). Both are registered/decoded from state; no combinational path from req_valid.
- req_valid held low: block stays IDLE, tx=1 indefinitely.
- Arithmetic: baud counter width = clog2(CLKS_PER_BIT). Bit index 3 bits. No wrap beyond 7.

Optional Feature:
- UART_PARITY_EN defined: a PARITY state is inserted between DATA and STOP, driving even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles. Frame becomes 11 bits; pair = 22*CLKS_PER_BIT cycles.
- Undefined: no PARITY state; 10-bit frames.

Decomposition:
- Package uart_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP).
  - FRAME_BITS constant (10, or 11 under UART_PARITY_EN).
  - BYTES_PER_PAIR = 2.
- Sub-module baud_tick: counter emitting a one-cycle tick every CLKS_PER_BIT clocks, with sync clear input and async active-low rst. Used by uart_resp_tx for bit timing.

Test Plan (CLK_HZ=16, BAUD=1 -> CLKS_PER_BIT=16):
- Reset: rst low mid-run -> tx=1, req_ready=1, busy=0, done=0 immediately. After release, tx stays 1 for 100 cycles with req_valid=0.
- Single pair: req_code=0x A5, req_data=0x3C, valid 1 cycle.
  - tx low the next cycle.
  - Sampling at bit centres yields 0,1,0,1,0,0,1,0,1,1, then 0,0,0,1,1,1,1,0,0,1.
  - done pulses once, 320 cycles after accept.
- Handshake: req_valid held high with changing data during transmission -> req_ready=0, the transmitted bytes equal those latched at accept, and no second accept occurs until the done cycle.
- Back-to-back: req_valid high continuously with pairs (0x01,0x02) then (0x03,0x04) -> the second start bit begins the cycle after done, and all 4 bytes decode correctly.
- Reset mid-frame: rst low at cycle 100 of a pair -> tx=1, no done pulse. A new pair after reset is transmitted fully and correctly.
- UART_PARITY_EN: data 0x07 -> parity bit 1. Data 0x03 -> parity bit 0. done comes 352 cycles after accept.
